// File: rtl/bmsce_mux_input_cond_if.sv
// Bus bundle for the mux input-conditioning stage.
//   master : drives ena and the raw pins, observes the conditioned outputs
//   slave  : the conditioning stage itself
// Signals:
//   ena         stage enable; 0 freezes all state
//   raw_sel/a/b unsynchronised select and data pins
//   sel/a/b     debounced levels feeding the 2:1 mux
//   sel_rise    one-cycle pulse on an accepted sel 0->1 change
//   sel_fall    one-cycle pulse on an accepted sel 1->0 change
//   sel_toggles wrapping count of accepted sel changes
interface bmsce_mux_input_cond_if;
    logic       ena;
    logic       raw_sel;
    logic       raw_a;
    logic       raw_b;
    logic       sel;
    logic       a;
    logic       b;
    logic       sel_rise;
    logic       sel_fall;
    logic [7:0] sel_toggles;

    modport master (
        output ena, raw_sel, raw_a, raw_b,
        input  sel, a, b, sel_rise, sel_fall, sel_toggles
    );

    modport slave (
        input  ena, raw_sel, raw_a, raw_b,
        output sel, a, b, sel_rise, sel_fall, sel_toggles
    );
endinterface

// File: rtl/bmsce_mux_input_cond.sv
// Input conditioning ahead of the 2:1 mux stage.
// Each of the three raw pins (sel, a, b) passes through a 2-flop synchroniser
// and a debouncer. A new level is accepted only after it has been present in
// the synchronised domain for DB_CYCLES consecutive cycles. Accepted sel changes
// also produce registered rise/fall pulses and bump a wrapping 8-bit counter.
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   cond_if  slave side of bmsce_mux_input_cond_if (ena, raw pins, outputs)
// Every output comes straight from a flop; no combinational path from raw_*.
module bmsce_mux_input_cond #(
    parameter int DB_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    bmsce_mux_input_cond_if.slave         cond_if
);

    localparam int CLOG = $clog2(DB_CYCLES + 1);
    localparam int CW   = (CLOG < 1) ? 1 : CLOG;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    // Channel index 0 = sel, 1 = a, 2 = b
    logic [2:0] raw_w;
    logic [2:0] stable_w;
    logic [2:0] stable_nxt_w;

    assign raw_w = {cond_if.raw_b, cond_if.raw_a, cond_if.raw_sel};

    for (genvar g = 0; g < 3; g++) begin : g_ch
        logic          s1_q, s1_d;
        logic          s2_q, s2_d;
        logic          stable_q, stable_d;
        logic [CW-1:0] cnt_q, cnt_d;

        always_comb begin
            s1_d     = s1_q;
            s2_d     = s2_q;
            cnt_d    = cnt_q;
            stable_d = stable_q;
            if (cond_if.ena) begin
                s1_d = raw_w[g];
                s2_d = s1_q;
                if (s2_q == stable_q) begin
                    // Any return to the accepted level abandons the run.
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    stable_d = s2_q;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_q     <= 1'b0;
                s2_q     <= 1'b0;
                cnt_q    <= '0;
                stable_q <= 1'b0;
            end else begin
                s1_q     <= s1_d;
                s2_q     <= s2_d;
                cnt_q    <= cnt_d;
                stable_q <= stable_d;
            end
        end

        assign stable_w[g]     = stable_q;
        assign stable_nxt_w[g] = stable_d;
    end

    logic       sel_rise_q, sel_rise_d;
    logic       sel_fall_q, sel_fall_d;
    logic [7:0] sel_toggles_q, sel_toggles_d;

    // Pulses look at the sel channel's next-state so they line up with the
    // edge that changes it; with ena low they clear and are not re-issued.
    always_comb begin
        sel_rise_d    = cond_if.ena &&  stable_nxt_w[0] && !stable_w[0];
        sel_fall_d    = cond_if.ena && !stable_nxt_w[0] &&  stable_w[0];
        sel_toggles_d = sel_toggles_q;
        if (sel_rise_d || sel_fall_d) begin
            sel_toggles_d = sel_toggles_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_rise_q    <= 1'b0;
            sel_fall_q    <= 1'b0;
            sel_toggles_q <= 8'd0;
        end else begin
            sel_rise_q    <= sel_rise_d;
            sel_fall_q    <= sel_fall_d;
            sel_toggles_q <= sel_toggles_d;
        end
    end

    assign cond_if.sel         = stable_w[0];
    assign cond_if.a           = stable_w[1];
    assign cond_if.b           = stable_w[2];
    assign cond_if.sel_rise    = sel_rise_q;
    assign cond_if.sel_fall    = sel_fall_q;
    assign cond_if.sel_toggles = sel_toggles_q;

endmodule

// File: tb/tb_bmsce_mux_input_cond.sv
// Directed bench for bmsce_mux_input_cond with DB_CYCLES = 4.
// Inputs change right after a falling edge; outputs are sampled on falling edges.
module tb_bmsce_mux_input_cond;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    int   rises;
    int   falls;
    int   both;
    int   first;

    bmsce_mux_input_cond_if bus ();

    bmsce_mux_input_cond #(.DB_CYCLES(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cond_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // Reset with all raw pins high
        bus.ena = 1'b1; bus.raw_sel = 1'b1; bus.raw_a = 1'b1; bus.raw_b = 1'b1;
        rst_n = 1'b0;
        tick(3);
        chk("rst_sel", int'(bus.sel), 0);
        chk("rst_a", int'(bus.a), 0);
        chk("rst_b", int'(bus.b), 0);
        chk("rst_rise", int'(bus.sel_rise), 0);
        chk("rst_fall", int'(bus.sel_fall), 0);
        chk("rst_toggles", int'(bus.sel_toggles), 0);

        // Release with raw_sel held high: sel accepted on the 6th sample
        rst_n = 1'b1; bus.raw_a = 1'b0; bus.raw_b = 1'b0;
        tick(5);
        chk("rel_sel_early", int'(bus.sel), 0);
        tick(1);
        chk("rel_sel_set", int'(bus.sel), 1);
        chk("rel_rise", int'(bus.sel_rise), 1);
        chk("rel_toggles", int'(bus.sel_toggles), 1);
        tick(1);
        chk("rel_rise_drop", int'(bus.sel_rise), 0);
        chk("rel_toggles_hold", int'(bus.sel_toggles), 1);

        // Glitch of 3 cycles on a is rejected
        bus.raw_a = 1'b1; tick(3); bus.raw_a = 1'b0;
        tick(10);
        chk("glitch3_a", int'(bus.a), 0);

        // 4-cycle pulse on a is accepted, then released again
        bus.raw_a = 1'b1; tick(4); bus.raw_a = 1'b0;
        tick(1);
        chk("pulse4_a_early", int'(bus.a), 0);
        tick(1);
        chk("pulse4_a_set", int'(bus.a), 1);
        tick(10);
        chk("pulse4_a_clear", int'(bus.a), 0);

        // Bring sel low, then bounce it 1,0,1,0,1
        bus.raw_sel = 1'b0; tick(10);
        chk("pre_bounce_sel", int'(bus.sel), 0);
        chk("pre_bounce_toggles", int'(bus.sel_toggles), 2);
        bus.raw_sel = 1'b1; tick(1);
        bus.raw_sel = 1'b0; tick(1);
        bus.raw_sel = 1'b1; tick(1);
        bus.raw_sel = 1'b0; tick(1);
        bus.raw_sel = 1'b1;
        rises = 0; falls = 0; first = 0;
        for (int i = 1; i <= 15; i++) begin
            tick(1);
            if (bus.sel_rise) rises++;
            if (bus.sel_fall) falls++;
            if (bus.sel && first == 0) first = i;
        end
        chk("bounce_rises", rises, 1);
        chk("bounce_falls", falls, 0);
        chk("bounce_latency", first, 6);
        chk("bounce_toggles", int'(bus.sel_toggles), 3);

        // Wrap: 256 clean transitions from a fresh reset
        rst_n = 1'b0; bus.raw_sel = 1'b0; bus.raw_a = 1'b0; bus.raw_b = 1'b0;
        tick(2);
        chk("wrap_rst_toggles", int'(bus.sel_toggles), 0);
        rst_n = 1'b1;
        tick(3);
        rises = 0; falls = 0; both = 0;
        for (int i = 0; i < 256; i++) begin
            bus.raw_sel = ~bus.raw_sel;
            for (int j = 0; j < 10; j++) begin
                tick(1);
                if (bus.sel_rise) rises++;
                if (bus.sel_fall) falls++;
                if (bus.sel_rise && bus.sel_fall) both++;
            end
            if (i == 254) chk("wrap_toggles_255", int'(bus.sel_toggles), 255);
        end
        chk("wrap_toggles_0", int'(bus.sel_toggles), 0);
        chk("wrap_rises", rises, 128);
        chk("wrap_falls", falls, 128);
        chk("wrap_both", both, 0);
        chk("wrap_sel", int'(bus.sel), 0);

        // Pulse drops when ena goes low and is not re-issued
        bus.raw_sel = 1'b1; tick(6);
        chk("ena_sel_set", int'(bus.sel), 1);
        chk("ena_rise", int'(bus.sel_rise), 1);
        chk("ena_toggles", int'(bus.sel_toggles), 1);
        bus.ena = 1'b0; tick(1);
        chk("ena_rise_drop", int'(bus.sel_rise), 0);
        chk("ena_toggles_hold", int'(bus.sel_toggles), 1);
        tick(3);
        bus.ena = 1'b1; tick(1);
        chk("ena_rise_no_reissue", int'(bus.sel_rise), 0);
        chk("ena_toggles_resume", int'(bus.sel_toggles), 1);

        // Freeze b mid-debounce (cnt=2) while raw pins move
        bus.raw_b = 1'b1; tick(4);
        bus.ena = 1'b0; bus.raw_b = 1'b0; bus.raw_sel = 1'b0; bus.raw_a = 1'b1;
        tick(20);
        chk("frz_b", int'(bus.b), 0);
        chk("frz_sel", int'(bus.sel), 1);
        chk("frz_a", int'(bus.a), 0);
        chk("frz_toggles", int'(bus.sel_toggles), 1);
        bus.raw_b = 1'b1; bus.raw_sel = 1'b1; bus.raw_a = 1'b0; bus.ena = 1'b1;
        tick(1);
        chk("frz_resume_b_early", int'(bus.b), 0);
        tick(1);
        chk("frz_resume_b_set", int'(bus.b), 1);
        tick(10);
        chk("frz_resume_sel", int'(bus.sel), 1);
        chk("frz_resume_a", int'(bus.a), 0);
        chk("frz_resume_toggles", int'(bus.sel_toggles), 1);

        // Six more sel changes to reach a count of 7, then reset mid-debounce on b
        for (int i = 0; i < 6; i++) begin
            bus.raw_sel = ~bus.raw_sel;
            tick(10);
        end
        bus.raw_b = 1'b0; tick(5);
        chk("arst_pre_b", int'(bus.b), 1);
        chk("arst_pre_sel", int'(bus.sel), 1);
        chk("arst_pre_toggles", int'(bus.sel_toggles), 7);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sel", int'(bus.sel), 0);
        chk("arst_a", int'(bus.a), 0);
        chk("arst_b", int'(bus.b), 0);
        chk("arst_rise", int'(bus.sel_rise), 0);
        chk("arst_fall", int'(bus.sel_fall), 0);
        chk("arst_toggles", int'(bus.sel_toggles), 0);
        bus.raw_sel = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(10);
        chk("post_arst_b", int'(bus.b), 0);
        chk("post_arst_sel", int'(bus.sel), 0);
        chk("post_arst_toggles", int'(bus.sel_toggles), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bmsce_mux_input_cond.md
Name: bmsce_mux_input_cond

Overview:
Input-conditioning stage that sits directly upstream of the 2:1 mux stage. It synchronises the raw select and data pins (sel, a, b) into the clock domain and debounces each one. It then delivers clean, glitch-free levels to the mux. It also reports select-edge pulses and a wrapping count of select changes for the spare output pins.

Parameters:
DB_CYCLES, 4, consecutive synchronised cycles a new level must persist before it is accepted (legal range 1..255)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  stage enable; 0 freezes all state
raw_sel  input  1  unsynchronised select pin (ui_in[0] upstream)
raw_a  input  1  unsynchronised data input a (ui_in[1])
raw_b  input  1  unsynchronised data input b (ui_in[2])
sel  output  1  debounced select, feeds mux sel
a  output  1  debounced a, feeds mux a
b  output  1  debounced b, feeds mux b
sel_rise  output  1  one-cycle pulse when sel changes 0->1
sel_fall  output  1  one-cycle pulse when sel changes 1->0
sel_toggles  output  8  count of accepted sel changes, wrapping

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, on rst_n.
- Reset values: all sync flops, debounce counters, sel, a, b, sel_rise, sel_fall and sel_toggles are 0. Reset asserted mid-debounce discards the in-progress count immediately, without waiting for a clock edge.
- Three identical channels (sel, a, b). Per channel:
  - s1 <= raw; s2 <= s1 (2-flop synchroniser).
  - If s2 == stable: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: stable <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - cnt width is max(1, clog2(DB_CYCLES+1)).
- Latency: raw level first sampled into s1 at edge k. If it is held, stable (the output) updates at edge k+DB_CYCLES+1. With DB_CYCLES=1 the update is at edge k+2.
- Glitch rejection: a level that persists in s2 for fewer than DB_CYCLES consecutive cycles never reaches the output. A return to the stable value resets cnt to 0.
- sel_rise / sel_fall:
  - Registered; high for exactly the one cycle following the edge at which stable_sel changes (0->1 or 1->0 respectively).
  - Never both high together.
  - Low otherwise.
- sel_toggles: increments by 1 on the same edge that sets sel_rise or sel_fall. Wraps 255 -> 0 with no saturation or flag.
- ena=0: all flops hold, including s1, s2, cnt, outputs and sel_toggles. Pulses drop to 0 on the next edge and are not re-issued. When ena returns to 1, operation resumes from the held state.
- Channels are fully independent. Simultaneous changes on sel, a and b debounce in parallel and may update on the same edge.
- Outputs sel, a and b are driven directly from flops, so there is no combinational path from the raw_* pins to any output.

Test Plan:
- Reset and hold (DB_CYCLES=4): rst_n=0 with raw_*=1 -> sel=a=b=0, sel_toggles=0, no pulses. Release with raw_sel=1 sampled at edge k -> sel=1 after edge k+5; sel_rise high for exactly one cycle; sel_toggles=1.
- Glitch rejection: raw_a pulsed high for 3 cycles, then low -> a stays 0 and no cnt overflow. Pulse held 4 cycles -> a=1 after the 5th edge from first sampling.
- Bounce: raw_sel toggled 1,0,1,0,1 on consecutive cycles, then held 1 -> exactly one sel_rise, one increment of sel_toggles, and sel=1 DB_CYCLES+1 edges after the final transition is sampled.
- Wrap: 256 clean sel transitions (alternating, each held 10 cycles) -> sel_toggles returns to 0. sel_rise count = 128 and sel_fall count = 128.
- ena freeze: ena=0 mid-debounce (cnt=2) for 20 cycles while raw changes -> outputs and cnt unchanged. ena=1 -> debounce resumes and completes per the rules above.
- Async reset mid-operation: rst_n pulsed low between clock edges while cnt=3 on b and sel_toggles=7 -> all outputs 0 immediately (before the next edge), sel_toggles=0.
